divider_req_sequencer: RTL and testbench

//  Upstream front-end for divider_core. Queues tagged divide requests from a

---
 rtl/divider_req_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_divider_req_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_req_sequencer.sv
// Request queue and issue sequencer in front of divider_core: buffers tagged
// divide requests, runs them one at a time, returns tagged results. Optional
// signed operation is enabled by defining DIVSEQ_SIGNED_EN.
module divider_req_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [31:0]      in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quot,
  output logic [31:0]      out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_err,
  output logic             busy,
  output logic             start_calc,
  output logic [31:0]      numerator,
  output logic [31:0]      denominator,
  input  logic             done_calc,
  input  logic [31:0]      div_output,
  input  logic [31:0]      div_remainder,
  output logic [1:0]       dbg_state
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready; the source holds valid and payload stable until then.

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = TAG_W + 64;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [AW:0]      DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic             start_q, start_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      den_q, den_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             full, empty, push, pop, load;
  logic [ENT_W-1:0] head;
  logic [31:0]      head_num, head_den;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      num_mag, den_mag;
  logic [31:0]      quot_fix, rem_fix;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign head_num = head[31:0];
  assign head_den = head[63:32];
  assign head_tag = head[64 +: TAG_W];

`ifdef DIVSEQ_SIGNED_EN
  // The core only sees magnitudes; signs are reapplied on capture
  // (quotient sign = xor of operand signs, remainder follows the numerator).
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign num_mag  = head_num[31] ? (~head_num + 32'd1) : head_num;
  assign den_mag  = head_den[31] ? (~head_den + 32'd1) : head_den;
  assign quot_fix = qneg_q ? (~div_output + 32'd1) : div_output;
  assign rem_fix  = rneg_q ? (~div_remainder + 32'd1) : div_remainder;
`else
  assign num_mag  = head_num;
  assign den_mag  = head_den;
  assign quot_fix = div_output;
  assign rem_fix  = div_remainder;
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    num_d       = num_q;
    den_d       = den_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
`ifdef DIVSEQ_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty) load = 1'b1;
      end
      S_CALC: begin
        if (done_calc) begin
          quot_d      = quot_fix;
          rem_d       = rem_fix;
          dbz_d       = (den_q == 32'd0);
          err_d       = 1'b0;
          start_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
          quot_d      = 32'd0;
          rem_d       = 32'd0;
          dbz_d       = (den_q == 32'd0);
          err_d       = 1'b1;
          start_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared issue path for IDLE and for the RESP-to-CALC shortcut.
    if (load) begin
      num_d   = num_mag;
      den_d   = den_mag;
      tag_d   = head_tag;
      start_d = 1'b1;
      cnt_d   = '0;
      state_d = S_CALC;
`ifdef DIVSEQ_SIGNED_EN
      qneg_d  = head_num[31] ^ head_den[31];
      rneg_d  = head_num[31];
`endif
    end
  end

  assign pop      = load;
  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      start_q     <= 1'b0;
      num_q       <= '0;
      den_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef DIVSEQ_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      start_q     <= start_d;
      num_q       <= num_d;
      den_q       <= den_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef DIVSEQ_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  // Queue storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_tag, in_den, in_num};
  end

  assign in_ready    = !full;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign start_calc  = start_q;
  assign numerator   = num_q;
  assign denominator = den_q;
  assign out_valid   = out_valid_q;
  assign out_quot    = quot_q;
  assign out_rem     = rem_q;
  assign out_tag     = tag_q;
  assign out_dbz     = dbz_q;
  assign out_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_divider_req_sequencer.sv
// Directed bench for divider_req_sequencer with a combinational divider core
// model; done_calc can be suppressed to exercise the abort path.
module tb_divider_req_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [31:0]      in_num, in_den;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_quot, out_rem;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz, out_err, busy;
  logic             start_calc;
  logic [31:0]      numerator, denominator;
  logic             done_calc;
  logic [31:0]      div_output, div_remainder;
  logic [1:0]       dbg_state;
  logic             core_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [67:0] exp_q[$];

  divider_req_sequencer #(
    .FIFO_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_tag(out_tag),
    .out_dbz(out_dbz), .out_err(out_err), .busy(busy),
    .start_calc(start_calc), .numerator(numerator), .denominator(denominator),
    .done_calc(done_calc), .div_output(div_output), .div_remainder(div_remainder),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // combinational divider core model
  assign done_calc     = start_calc && core_en;
  assign div_output    = (denominator != 32'd0) ? numerator / denominator : 32'd0;
  assign div_remainder = (denominator != 32'd0) ? numerator % denominator : numerator;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] num, input logic [31:0] den, input logic [TAG_W-1:0] tag);
    check("push_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_num   = num;
    in_den   = den;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  // scoreboard: compares every result handshake against exp_q
  task automatic collect(input int n, input bit check_gap);
    int got = 0;
    int last = -1;
    int cyc = 0;
    logic [67:0] e;
    while (got < n && cyc < 200) begin
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("result", {out_tag, out_quot, out_rem}, e);
        if (check_gap && last >= 0) check("gap", 68'(cyc - last), 68'd2);
        last = cyc;
        got++;
      end
      step();
      cyc++;
    end
    if (got < n) check("collect_timeout", 68'(got), 68'(n));
  endtask

  initial begin
    int seen;
    in_valid  = 1'b0;
    in_num    = '0;
    in_den    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    core_en   = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_start", start_calc, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_payload", {out_tag, out_quot, out_rem}, 68'd0);
    check("rst_flags", {out_dbz, out_err}, 2'b00);
    check("rst_operands", {numerator, denominator}, 64'd0);
    rst_n = 1'b1;
    step();

    // basic divide and latency
    out_ready = 1'b1;
    push(32'd100, 32'd7, 4'd3);
    check("t1_busy", busy, 1'b1);
    step();
    check("t1_start", start_calc, 1'b1);
    check("t1_valid_early", out_valid, 1'b0);
    check("t1_operands", {numerator, denominator}, {32'd100, 32'd7});
    step();
    check("t1_valid", out_valid, 1'b1);
    check("t1_result", {out_tag, out_quot, out_rem}, {4'd3, 32'd14, 32'd2});
    check("t1_flags", {out_dbz, out_err}, 2'b00);
    step();
    check("t1_valid_drop", out_valid, 1'b0);
    check("t1_idle", busy, 1'b0);

    // divide by zero
    push(32'd55, 32'd0, 4'd5);
    step();
    step();
    check("dbz_valid", out_valid, 1'b1);
    check("dbz_result", {out_tag, out_quot, out_rem}, {4'd5, 32'd0, 32'd55});
    check("dbz_flags", {out_dbz, out_err}, 2'b10);
    step();

    // queue fill with back-pressure, then in-order drain
    out_ready = 1'b0;
    exp_q.push_back({4'd1, 32'd10, 32'd1});
    exp_q.push_back({4'd2, 32'd7,  32'd1});
    exp_q.push_back({4'd3, 32'd5,  32'd3});
    exp_q.push_back({4'd4, 32'd4,  32'd4});
    exp_q.push_back({4'd5, 32'd4,  32'd1});
    for (int k = 1; k <= 5; k++) begin
      check("fill_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_num   = 32'(20 + k);
      in_den   = 32'(k + 1);
      in_tag   = 4'(k);
      step();
    end
    check("fill_full", in_ready, 1'b0);
    in_num = 32'd99;
    in_den = 32'd9;
    in_tag = 4'd6;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("fill_hold_valid", out_valid, 1'b1);
    check("fill_hold_tag", out_tag, 4'd1);
    check("fill_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    collect(5, 1'b1);
    check("drain_idle", busy, 1'b0);
    check("drain_valid", out_valid, 1'b0);

    // abort when the core never answers
    core_en   = 1'b0;
    out_ready = 1'b0;
    push(32'd50, 32'd5, 4'd9);
    repeat (16) step();
    check("to_not_yet", out_valid, 1'b0);
    check("to_start_held", start_calc, 1'b1);
    step();
    check("to_valid", out_valid, 1'b1);
    check("to_err", out_err, 1'b1);
    check("to_result", {out_tag, out_quot, out_rem}, {4'd9, 32'd0, 32'd0});
    check("to_start_drop", start_calc, 1'b0);
    out_ready = 1'b1;
    step();
    check("to_done", out_valid, 1'b0);
    core_en = 1'b1;

    // asynchronous reset while in CALC with two entries queued
    core_en = 1'b0;
    push(32'd10, 32'd2, 4'd1);
    push(32'd12, 32'd3, 4'd2);
    push(32'd14, 32'd7, 4'd3);
    step();
    check("ar_calc", start_calc, 1'b1);
    check("ar_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check("ar_start", start_calc, 1'b0);
    check("ar_valid", out_valid, 1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_busy_clr", busy, 1'b0);
    check("ar_operands", {numerator, denominator}, 64'd0);
    check("ar_payload", {out_tag, out_quot, out_rem, out_dbz, out_err}, 70'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    core_en = 1'b1;
    seen    = 0;
    repeat (10) begin
      step();
      if (out_valid || start_calc) seen++;
    end
    check("ar_no_stale", 68'(seen), 68'd0);
    check("ar_idle", busy, 1'b0);

`ifdef DIVSEQ_SIGNED_EN
    // signed operands
    out_ready = 1'b1;
    push(32'hFFFF_FFF9, 32'd2, 4'd4);
    step();
    check("s_mag", {numerator, denominator}, {32'd7, 32'd2});
    step();
    check("s_neg7_2", {out_tag, out_quot, out_rem}, {4'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    step();
    push(32'h8000_0000, 32'hFFFF_FFFF, 4'd6);
    step();
    step();
    check("s_min_m1", {out_tag, out_quot, out_rem}, {4'd6, 32'h8000_0000, 32'd0});
    step();
    push(32'hFFFF_FFC9, 32'd0, 4'd7);
    step();
    step();
    check("s_dbz", {out_tag, out_quot, out_rem}, {4'd7, 32'd0, 32'hFFFF_FFC9});
    check("s_dbz_flag", out_dbz, 1'b1);
    step();
`else
    // unsigned pass-through of a large operand
    out_ready = 1'b1;
    push(32'hFFFF_FFFF, 32'd2, 4'd8);
    step();
    step();
    check("u_large", {out_tag, out_quot, out_rem}, {4'd8, 32'h7FFF_FFFF, 32'd1});
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
